// File: rtl/hartslag_meter.sv
// rtl/hartslag_meter.sv - heartbeat pulse to BPM: sync, debounce, period measurement, divider
module hartslag_meter #(
  parameter int CNT_W         = 16,
  parameter int TICKS_PER_MIN = 60000,
  parameter int DEBOUNCE      = 4,
  parameter int MIN_PERIOD    = 200,
  parameter int TIMEOUT       = 3000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       hartslagIngang,
  output logic [7:0] hartslag,
  output logic       hartslagValid,
  output logic       hartslagNew,
  output logic       hartslagError
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int BC_W = $clog2(CNT_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] DIVIDEND  = CNT_W'(TICKS_PER_MIN);
  localparam logic [CNT_W-1:0] MIN_P     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic              level_q, level_d, level_prev_q, level_prev_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              armed_q, armed_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  rem_q, rem_d, dvd_q, dvd_d, quo_q, quo_d;
  logic [BC_W-1:0]   bit_q, bit_d;
  logic [7:0]        hs_q, hs_d;
  logic              valid_q, valid_d, new_q, new_d, err_q, err_d;

  logic              beat, start, timeout;
  logic [CNT_W-1:0]  cnt_inc, cnt_restart;
  logic [CNT_W:0]    rem_shift;
  logic [CNT_W-1:0]  rem_sub;
  logic              q_bit;

  assign sync1_d      = hartslagIngang;
  assign sync2_d      = sync1_q;
  assign level_prev_d = level_q;
  assign beat         = level_q & ~level_prev_q;

  // A differing level must survive DEBOUNCE ticks in a row to be accepted.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync2_q != level_q) begin
      db_cnt_d = db_cnt_q;
      if (tick) begin
        if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
          level_d  = ~level_q;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
    end
  end

  assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign cnt_restart = tick ? CNT_W'(1) : '0;

  // A beat outranks a timeout landing in the same cycle.
  always_comb begin
    cnt_d    = tick ? cnt_inc : cnt_q;
    armed_d  = armed_q;
    start    = 1'b0;
    timeout  = 1'b0;
    if (beat) begin
      if (!armed_q) begin
        armed_d = 1'b1;
        cnt_d   = cnt_restart;
      end else if (cnt_q >= MIN_P) begin
        cnt_d = cnt_restart;
        start = (state_q == S_IDLE);
      end
    end else if (armed_q && (cnt_q == TIMEOUT_C)) begin
      armed_d = 1'b0;
      timeout = 1'b1;
    end
  end

  assign period_d  = start ? cnt_q : period_q;
  assign rem_shift = {rem_q, dvd_q[CNT_W-1]};
  assign q_bit     = (rem_shift >= {1'b0, period_q});
  assign rem_sub   = rem_shift[CNT_W-1:0] - period_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_DIV;
      S_DIV:  if (bit_q == BC_W'(CNT_W - 1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    bit_d   = bit_q;
    hs_d    = hs_q;
    valid_d = valid_q;
    new_d   = 1'b0;
    err_d   = err_q;
    if (timeout) begin
      err_d   = 1'b1;
      valid_d = 1'b0;
      hs_d    = 8'd0;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d = '0;
          dvd_d = DIVIDEND;
          quo_d = '0;
          bit_d = '0;
        end
      end
      S_DIV: begin
        rem_d = q_bit ? rem_sub : rem_shift[CNT_W-1:0];
        dvd_d = {dvd_q[CNT_W-2:0], 1'b0};
        quo_d = {quo_q[CNT_W-2:0], q_bit};
        bit_d = bit_q + BC_W'(1);
      end
      S_DONE: begin
        hs_d    = (quo_q > CNT_W'(255)) ? 8'hFF : quo_q[7:0];
        valid_d = 1'b1;
        err_d   = 1'b0;
        new_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      db_cnt_q     <= '0;
      cnt_q        <= '0;
      armed_q      <= 1'b0;
      period_q     <= '0;
      rem_q        <= '0;
      dvd_q        <= '0;
      quo_q        <= '0;
      bit_q        <= '0;
      hs_q         <= 8'd0;
      valid_q      <= 1'b0;
      new_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      db_cnt_q     <= db_cnt_d;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
      period_q     <= period_d;
      rem_q        <= rem_d;
      dvd_q        <= dvd_d;
      quo_q        <= quo_d;
      bit_q        <= bit_d;
      hs_q         <= hs_d;
      valid_q      <= valid_d;
      new_q        <= new_d;
      err_q        <= err_d;
    end
  end

  assign hartslag      = hs_q;
  assign hartslagValid = valid_q;
  assign hartslagNew   = new_q;
  assign hartslagError = err_q;

endmodule

// File: tb/tb_hartslag_meter.sv
// tb/tb_hartslag_meter.sv - bench for hartslag_meter against a beat-level rate model
module tb_hartslag_meter;

  localparam int CNT_W = 16;
  localparam int TPM   = 60000;
  localparam int DEB   = 2;
  localparam int MINP  = 200;
  localparam int TOUT  = 3000;
  // input change driven after edge K is sampled at K+1, then 1 more sync flop and DEB ticks
  localparam int BEAT_DLY = 2 + DEB;
  localparam int STROBE_DLY = CNT_W + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b1;
  logic       hin = 1'b0;
  logic [7:0] hartslag;
  logic       hartslagValid, hartslagNew, hartslagError;

  hartslag_meter #(
    .CNT_W(CNT_W), .TICKS_PER_MIN(TPM), .DEBOUNCE(DEB), .MIN_PERIOD(MINP), .TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .hartslagIngang(hin),
    .hartslag(hartslag), .hartslagValid(hartslagValid),
    .hartslagNew(hartslagNew), .hartslagError(hartslagError)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  bit m_armed = 1'b0;
  int m_last = 0;
  int m_idle_at = 0;
  int exp_cyc[$];
  int exp_val[$];
  int last_k = 0;

  // Beat-level model: rate = TPM / beat spacing, saturated at 255.
  task automatic model_beat(input int bt);
    int p;
    int rate;
    if (m_armed && (bt - m_last > TOUT)) m_armed = 1'b0;
    if (!m_armed) begin
      m_armed = 1'b1;
      m_last  = bt;
    end else if (bt - m_last >= MINP) begin
      p      = bt - m_last;
      m_last = bt;
      if (bt >= m_idle_at) begin
        rate = TPM / p;
        if (rate > 255) rate = 255;
        exp_cyc.push_back(bt + STROBE_DLY);
        exp_val.push_back(rate);
        m_idle_at = bt + STROBE_DLY;
      end
    end
  endtask

  task automatic model_reset();
    m_armed   = 1'b0;
    m_idle_at = 0;
    exp_cyc.delete();
    exp_val.delete();
  endtask

  bit prev_new = 1'b0;
  int mon_c, mon_v;
  always @(negedge clk) begin
    if (reset) begin
      if (hartslagNew) begin
        checks++;
        if (prev_new) begin
          errors++;
          $display("FAIL strobe_width: hartslagNew high 2 cycles at cyc %0d, expected 1", cyc);
        end
        if (exp_cyc.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got strobe at cyc %0d value %0d, expected none", cyc, hartslag);
        end else begin
          mon_c = exp_cyc.pop_front();
          mon_v = exp_val.pop_front();
          checks += 4;
          if (cyc !== mon_c) begin
            errors++;
            $display("FAIL strobe_time: got cyc %0d, expected %0d", cyc, mon_c);
          end
          if (hartslag !== mon_v[7:0]) begin
            errors++;
            $display("FAIL strobe_value: got %0d, expected %0d", hartslag, mon_v);
          end
          if (hartslagValid !== 1'b1) begin
            errors++;
            $display("FAIL strobe_valid: got %b, expected 1", hartslagValid);
          end
          if (hartslagError !== 1'b0) begin
            errors++;
            $display("FAIL strobe_error: got %b, expected 0", hartslagError);
          end
        end
      end
      prev_new <= hartslagNew;
    end else begin
      prev_new <= 1'b0;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic drive_edge(input int spacing, input int hi);
    wait_until(last_k + spacing);
    hin    = 1'b1;
    last_k = cyc;
    model_beat(cyc + BEAT_DLY);
    wait_cycles(hi);
    hin = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget = 0;
    while (exp_cyc.size() != 0 && budget < 60) begin
      @(posedge clk); #1;
      budget++;
    end
    checks++;
    if (exp_cyc.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d strobes outstanding, expected 0", name, exp_cyc.size());
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] hs, input logic v, input logic e);
    checks += 3;
    if (hartslag !== hs) begin
      errors++;
      $display("FAIL %s_hartslag: got %0d, expected %0d", name, hartslag, hs);
    end
    if (hartslagValid !== v) begin
      errors++;
      $display("FAIL %s_valid: got %b, expected %b", name, hartslagValid, v);
    end
    if (hartslagError !== e) begin
      errors++;
      $display("FAIL %s_error: got %b, expected %b", name, hartslagError, e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    hin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 8'd0, 1'b0, 1'b0);
    checks++;
    if (hartslagNew !== 1'b0) begin
      errors++;
      $display("FAIL reset_new: got %b, expected 0", hartslagNew);
    end
    reset = 1'b1;
    model_reset();
    last_k = cyc;
  endtask

  task automatic test_steady_120();
    drive_edge(10, 20);
    wait_cycles(30);
    check_out("arm_only", 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_edge(500, 20);
      drain("steady");
    end
    check_out("steady", 8'd120, 1'b1, 1'b0);
  endtask

  task automatic test_rate_change();
    drive_edge(1000, 20);
    drain("rate60");
    check_out("rate60", 8'd60, 1'b1, 1'b0);
    drive_edge(250, 20);
    drain("rate240");
    check_out("rate240", 8'd240, 1'b1, 1'b0);
  endtask

  task automatic test_saturate_artifact();
    drive_edge(200, 20);
    drain("sat");
    check_out("sat", 8'd255, 1'b1, 1'b0);
    drive_edge(150, 20);
    drive_edge(50, 20);
    drain("artifact");
    check_out("artifact", 8'd255, 1'b1, 1'b0);
  endtask

  task automatic test_glitch();
    drive_edge(500, 20);
    drain("pre_glitch");
    wait_until(last_k + 250);
    hin = 1'b1;
    wait_cycles(1);
    hin = 1'b0;
    drive_edge(500, 20);
    drain("glitch");
    check_out("glitch", 8'd120, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    int bt;
    bt = m_last;
    wait_until(bt + TOUT - 5);
    check_out("pre_timeout", 8'd120, 1'b1, 1'b0);
    wait_until(bt + TOUT + 3);
    check_out("timeout", 8'd0, 1'b0, 1'b1);
    drive_edge(3200, 20);
    wait_cycles(40);
    check_out("rearm", 8'd0, 1'b0, 1'b1);
    drive_edge(500, 20);
    drain("recover");
    check_out("recover", 8'd120, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_div();
    int k;
    drive_edge(500, 5);
    k = last_k;
    wait_until(k + BEAT_DLY + 5);
    reset = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check_out("mid_reset", 8'd0, 1'b0, 1'b0);
    checks++;
    if (hartslagNew !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_new: got %b, expected 0", hartslagNew);
    end
    reset = 1'b1;
    wait_cycles(40);
    check_out("post_reset", 8'd0, 1'b0, 1'b0);
    last_k = cyc;
    drive_edge(5, 20);
    wait_cycles(30);
    check_out("post_reset_arm", 8'd0, 1'b0, 1'b0);
    drive_edge(500, 20);
    drain("post_reset");
    check_out("post_reset_meas", 8'd120, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int sp;
    for (int i = 0; i < 12; i++) begin
      sp = int'($urandom_range(1400, 60));
      drive_edge(sp, 20);
      drain("random");
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    #1;
    test_reset();
    test_steady_120();
    test_rate_change();
    test_saturate_artifact();
    test_glitch();
    test_timeout();
    test_reset_mid_div();
    test_back_to_back();
    wait_cycles(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hartslag_meter.md
Name: hartslag_meter

Overview:
Upstream input stage that turns the raw heartbeat pulse (hartslagIngang) into an 8-bit beats-per-minute value, hartslag, for the controller. It contains:
- a synchroniser and tick-based debouncer on the pulse input;
- a beat-to-beat period counter with artifact rejection and a timeout;
- a sequential restoring divider that computes TICKS_PER_MIN / period.
It runs on clk, and time is measured with the tick enable supplied by the slow-clock divider.

Parameters:
CNT_W, 16, width of the period counter, divider operands and quotient
TICKS_PER_MIN, 60000, ticks in one minute (1 ms tick); must fit in CNT_W bits
DEBOUNCE, 4, consecutive ticks a new input level must hold before it is accepted
MIN_PERIOD, 200, shortest accepted beat period in ticks; shorter beats are artifacts
TIMEOUT, 3000, ticks without an accepted beat before error; constraint CNT_W+2 < MIN_PERIOD < TIMEOUT

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
tick  in  1  time-base enable, one clk wide
hartslagIngang  in  1  raw asynchronous heartbeat pulse
hartslag  out  8  heart rate in BPM, saturated at 255
hartslagValid  out  1  hartslag holds a current measurement
hartslagNew  out  1  one-cycle strobe when hartslag is updated
hartslagError  out  1  no beat detected within TIMEOUT ticks

Behaviour:
- Reset (reset=0 sampled at a clk edge):
  - sync flops, debounced level, debounce counter, period counter, armed flag and pending period all go to 0;
  - FSM goes to IDLE;
  - hartslag=0, hartslagValid=0, hartslagNew=0, hartslagError=0.
  - Reset mid-division abandons the division; no strobe is issued.
- Synchroniser: 2-flop chain on hartslagIngang.
- Debouncer:
  - when the sync output differs from the debounced level, the counter increments on each tick;
  - when the counter reaches DEBOUNCE, the debounced level toggles and the counter clears;
  - any cycle where the sync output equals the debounced level clears the counter.
- beat: one-clk pulse on the rising edge of the debounced level.
- Period counter:
  - increments on tick and saturates at 2^CNT_W-1;
  - where "counter restarts" is stated below, it loads 1 if tick is high in that cycle, else 0.
- On beat:
  - armed=0: set armed=1, restart the counter, no measurement.
  - armed=1 and count < MIN_PERIOD: beat ignored; counter and armed are untouched.
  - armed=1 and count >= MIN_PERIOD: period := count, counter restarts.
    - If FSM is IDLE, the divider starts.
    - If FSM is busy, the period is discarded; the counter still restarts.
- Timeout:
  - when armed=1 and count reaches TIMEOUT: armed=0, hartslagError=1, hartslagValid=0, hartslag=0;
  - the counter keeps saturating;
  - the next beat only re-arms;
  - error clears at the next hartslagNew.
- Divider FSM: IDLE -> DIV -> DONE -> IDLE.
  - IDLE: waits for an accepted period.
  - DIV: restoring division of TICKS_PER_MIN by period, one quotient bit per clk, exactly CNT_W cycles, MSB first.
  - DONE, for 1 cycle:
    - hartslag := (quotient > 255) ? 255 : quotient[7:0];
    - hartslagValid := 1, hartslagError := 0, hartslagNew pulses 1.
- Latency: hartslagNew is high exactly CNT_W+2 clks after the clk in which beat is high. Outputs are registered and hold their value between updates.
- Simultaneous events:
  - A beat in the same cycle as a timeout takes priority: the beat is processed with the pre-timeout armed state, and the timeout is not flagged.
  - A tick in the same cycle as a beat is handled by the counter-restart rule above.
- hartslagNew is never high for more than 1 cycle. No new division starts in the DONE cycle.

Test Plan:
Bench parameters: DEBOUNCE=2, tick tied high, defaults otherwise.
1. Clean pulses, rising edges 500 clks apart, ×4 -> first edge arms with no strobe; each later edge gives hartslagNew 18 clks after beat, hartslag=120, hartslagValid=1.
2. Edges 1000 clks apart -> hartslag=60. Change to 250 clks apart -> next update hartslag=240, with no intermediate strobe.
3. Edges 200 clks apart (quotient 300) -> hartslag=255. Insert an extra edge 150 clks after a beat -> that edge is ignored; the following 200-clk edge still measures 200.
4. 1-clk high glitch between beats -> no beat, counter unaffected, no strobe; the measured value is unchanged.
5. Stop pulses after a valid 120 -> 3000 ticks after the last beat: hartslagError=1, hartslagValid=0, hartslag=0. Next edge gives no strobe; the edge 500 clks later gives hartslag=120 and hartslagError=0.
6. Assert reset=0 for 1 clk, 5 clks into DIV -> all outputs 0, no strobe. After release, the first edge only arms.
